// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Ports: clk, rst (async high), start, abort, op[2:0], rs, rt -> busy, done, div_zero, hi, lo.
module mdu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] cnt;
  // mul: {partial product high, multiplier being shifted out}
  // div: low half holds the dividend shifting out / quotient shifting in
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem;
  // multiplicand (mul) or divisor (div) magnitude
  logic [W-1:0]   opb;
  logic           is_div;
  logic           by_zero;
  logic           q_neg;
  logic           r_neg;
  logic           dz_save;

  logic           op_mul, op_div, op_mthi, op_mtlo;
  logic           signed_op, rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag;
  logic           accept, last, kill;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ok;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rmd;

  assign op_mul    = (op == 3'd0) | (op == 3'd1);
  assign op_div    = (op == 3'd2) | (op == 3'd3);
  assign op_mthi   = (op == 3'd4);
  assign op_mtlo   = (op == 3'd5);
  assign signed_op = ~op[0];
  assign rs_neg    = signed_op & rs[W-1];
  assign rt_neg    = signed_op & rt[W-1];
  // magnitude of the most-negative value wraps to itself, read as unsigned
  assign rs_mag    = rs_neg ? -rs : rs;
  assign rt_mag    = rt_neg ? -rt : rt;

  assign busy   = (state != IDLE);
  assign kill   = abort & busy;
  // abort wins over start even when idle
  assign accept = start & ~abort & ~busy;
  assign last   = (cnt == CNT_WIDTH'(W - 1));

  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_shift = {rem, acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  // no borrow means the trial subtraction fits
  assign div_ok    = ~div_diff[W];

  assign prod = q_neg ? -acc : acc;
  assign quo  = q_neg ? -acc[W-1:0] : acc[W-1:0];
  assign rmd  = r_neg ? -rem : rem;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept & op_mul)
          state_nxt = MUL;
        else if (accept & op_div)
          state_nxt = (rt == '0) ? FIX : DIV;
      end
      MUL: if (last) state_nxt = FIX;
      DIV: if (last) state_nxt = FIX;
      FIX: state_nxt = IDLE;
    endcase
    if (kill)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      by_zero  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz_save  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // start cleared the flag; put back what it was before
        div_zero <= dz_save;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (op_mthi)
                hi <= rs;
              if (op_mtlo)
                lo <= rs;
              if (op_mul | op_div | op_mthi | op_mtlo) begin
                div_zero <= 1'b0;
                dz_save  <= div_zero;
              end
              if (op_mul | op_div) begin
                cnt     <= '0;
                rem     <= '0;
                is_div  <= op_div;
                by_zero <= op_div & (rt == '0);
                q_neg   <= rs_neg ^ rt_neg;
                r_neg   <= rs_neg;
                opb     <= op_mul ? rs_mag : rt_mag;
                // divide-by-zero keeps the raw rs for hi
                acc     <= {{W{1'b0}},
                            op_mul ? rt_mag :
                            (rt == '0) ? rs : rs_mag};
              end
            end
          end
          MUL: begin
            acc <= {mul_sum, acc[W-1:1]};
            cnt <= cnt + 1'b1;
          end
          DIV: begin
            rem          <= div_ok ? div_diff[W-1:0]
                                   : div_shift[W-1:0];
            acc[W-1:0]   <= {acc[W-2:0], div_ok};
            cnt          <= cnt + 1'b1;
          end
          FIX: begin
            done <= 1'b1;
            if (by_zero) begin
              lo       <= '1;
              hi       <= acc[W-1:0];
              div_zero <= 1'b1;
            end else if (is_div) begin
              lo <= quo;
              hi <= rmd;
            end else begin
              {hi, lo} <= prod;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: 32-bit instance against a
// behavioural model every cycle, plus literal vectors on 32- and 8-bit units.
module tb_mdu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8, abort8;
  logic [2:0]  op8;
  logic [7:0]  rs8, rt8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  mdu_multicycle #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  mdu_multicycle #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .op(op8),
    .rs(rs8), .rt(rt8), .busy(busy8), .done(done8), .div_zero(div_zero8),
    .hi(hi8), .lo(lo8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (32-bit) ----------------
  function automatic void golden(input logic [2:0] o,
                                 input logic [31:0] a, b,
                                 output logic [31:0] h, l,
                                 output bit z);
    logic [63:0] p;
    int sa, sb;
    z  = 0;
    h  = 0;
    l  = 0;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {h, l} = p; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          l = '1; h = a; z = 1;
        end else if (o == 3'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a; h = 0;
          end else begin
            l = sa / sb; h = sa % sb;
          end
        end else begin
          l = a / b; h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_dz, p_dz, m_done, dz_save;
  int          left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_dz = 0; m_done = 0; left = 0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        if (abort) begin
          left = 0;
          m_dz = dz_save;
        end else begin
          left--;
          if (left == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
            if (p_dz) m_dz = 1;
            m_done = 1;
          end
        end
      end else if (start && !abort && op <= 3'd5) begin
        dz_save = m_dz;
        m_dz = 0;
        if (op == 3'd4) m_hi = rs;
        else if (op == 3'd5) m_lo = rs;
        else begin
          golden(op, rs, rt, p_hi, p_lo, p_dz);
          left = p_dz ? 1 : 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, left > 0);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("div_zero", div_zero, m_dz);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input bit w8, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 1; k <= 100; k++) begin
      if (w8 ? busy8 : busy) bc++;
      if (w8 ? done8 : done) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: done never seen (w8=%0d)", w8);
    end
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] a, b,
                       output int lat, output int bc);
    @(negedge clk);
    start = 1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 0;
    wait_done(0, lat, bc);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, b,
                      output int lat, output int bc);
    @(negedge clk);
    start8 = 1; op8 = o; rs8 = a; rt8 = b;
    @(negedge clk);
    start8 = 0;
    wait_done(1, lat, bc);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    int          lat;
    bit          dz;
  } vec_t;

  vec_t vecs[10] = '{
    '{3'd0, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 0},
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0},
    '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33, 0},
    '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0},
    '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 0},
    '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         33, 0},
    '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33, 0},
    '{3'd3, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 33, 0},
    '{3'd1, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 33, 0},
    '{3'd2, 32'h0000_1234, 32'h0,         32'h1234,      32'hFFFF_FFFF, 1,  1}
  };

  int  lat, bc;
  bit  saw_done;

  initial begin
    rst = 1; start = 0; abort = 0; op = 0; rs = 0; rt = 0;
    start8 = 0; abort8 = 0; op8 = 0; rs8 = 0; rt8 = 0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi8", hi8, 0);
    check("rst_busy8", busy8, 0);
    rst = 0;

    foreach (vecs[i]) begin
      run32(vecs[i].o, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busycyc", i), bc, vecs[i].lat);
      check($sformatf("v%0d_hi", i), hi, vecs[i].eh);
      check($sformatf("v%0d_lo", i), lo, vecs[i].el);
      check($sformatf("v%0d_dz", i), div_zero, vecs[i].dz);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 0);
    end

    // MTLO clears the sticky flag; then MTHI/MTLO back to back
    start = 1; op = 3'd5; rs = 32'h77;
    @(negedge clk);
    check("mtlo_dz_clr", div_zero, 0);
    check("mtlo_lo", lo, 32'h77);
    check("mtlo_busy", busy, 0);
    op = 3'd4; rs = 32'hAAAA;
    @(negedge clk);
    check("mthi_busy", busy, 0);
    op = 3'd5; rs = 32'h5555;
    @(negedge clk);
    start = 0;
    check("mt_busy", busy, 0);
    check("mt_hi", hi, 32'hAAAA);
    check("mt_lo", lo, 32'h5555);

    // MULT with an ignored start at cycle 5 and abort at cycle 10
    start = 1; op = 3'd0; rs = 32'd5; rt = 32'd6;
    @(negedge clk);
    start = 0;
    saw_done = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin start = 1; op = 3'd3; rs = 32'd9; rt = 32'd2; end
      if (c == 6) start = 0;
      if (c == 10) abort = 1;
      if (c == 11) abort = 0;
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", saw_done, 0);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 32'hAAAA);
    check("abort_lo", lo, 32'h5555);

    // abort restores a div_zero that was set before the start
    run32(3'd2, 32'h55, 32'h0, lat, bc);
    start = 1; op = 3'd3; rs = 32'd9; rt = 32'd2;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_dz_kept", div_zero, 1);
    check("abort_dz_hi", hi, 32'h55);
    check("abort_dz_lo", lo, 32'hFFFF_FFFF);
    check("abort_dz_busy", busy, 0);

    // async reset in the middle of a DIV
    start = 1; op = 3'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (11) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dz", div_zero, 0);
    @(negedge clk);
    rst = 0;

    // 8-bit instance
    run8(3'd0, 8'hFD, 8'h07, lat, bc);
    check("w8_mult_lat", lat, 9);
    check("w8_mult_busy", bc, 9);
    check("w8_mult_hi", hi8, 8'hFF);
    check("w8_mult_lo", lo8, 8'hEB);
    run8(3'd3, 8'd100, 8'd7, lat, bc);
    check("w8_divu_lat", lat, 9);
    check("w8_divu_hi", hi8, 8'd2);
    check("w8_divu_lo", lo8, 8'd14);
    run8(3'd2, 8'h80, 8'hFF, lat, bc);
    check("w8_ovf_hi", hi8, 8'h00);
    check("w8_ovf_lo", lo8, 8'h80);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
